riscv_hwloop_controller: RTL

- Consumer side of the hardware-loop register file.
- Reads per-loop start, end and counter values and compares the ID-stage PC against each loop end address.
- Emits a one-hot decrement request back to the register file.
- Drives a registered jump request and target to the prefetcher, held until the prefetcher acknowledges it.

---
 rtl/riscv_hwlp_pkg.sv | 12 +
 rtl/riscv_hwlp_match.sv | 48 ++++
 rtl/riscv_hwloop_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/riscv_hwlp_pkg.sv
// riscv_hwlp_pkg: shared constants and FSM state type for the hardware-loop controller
// Holds the default loop count, loop-index width, address width and controller state enum.
package riscv_hwlp_pkg;
    localparam int N_HWLP_DEFAULT      = 2;
    localparam int N_HWLP_BITS_DEFAULT = $clog2(N_HWLP_DEFAULT);
    localparam int HWLP_ADDR_W         = 32;

    typedef enum logic {
        IDLE     = 1'b0,
        JUMP_REQ = 1'b1
    } hwlp_ctrl_state_e;
endpackage

// File: rtl/riscv_hwlp_match.sv
// riscv_hwlp_match: per-loop end-address comparators plus lowest-index priority encoder
// Ports:
//   current_pc_i    - PC of the instruction in ID
//   instr_valid_i   - ID instruction valid
//   hwlp_end_addr_i - packed loop end addresses, loop i at [32i+31:32i]
//   hwlp_counter_i  - packed remaining iteration counts, same packing
//   match_any_o     - at least one active loop ends at current_pc_i
//   sel_o           - lowest matching loop index (loop 0 is innermost)
//   last_iter_o     - the selected loop's counter equals 1
module riscv_hwlp_match
    import riscv_hwlp_pkg::*;
#(
    parameter int N_HWLP      = N_HWLP_DEFAULT,
    parameter int N_HWLP_BITS = N_HWLP_BITS_DEFAULT
) (
    input  logic [HWLP_ADDR_W-1:0]        current_pc_i,
    input  logic                          instr_valid_i,
    input  logic [N_HWLP*HWLP_ADDR_W-1:0] hwlp_end_addr_i,
    input  logic [N_HWLP*HWLP_ADDR_W-1:0] hwlp_counter_i,
    output logic                          match_any_o,
    output logic [N_HWLP_BITS-1:0]        sel_o,
    output logic                          last_iter_o
);
    logic [HWLP_ADDR_W-1:0] cnt [N_HWLP];
    logic [N_HWLP-1:0]      match;

    for (genvar g = 0; g < N_HWLP; g++) begin : g_cmp
        assign cnt[g]   = hwlp_counter_i[g*HWLP_ADDR_W +: HWLP_ADDR_W];
        // a zero counter marks the loop as inactive
        assign match[g] = instr_valid_i
                          && (current_pc_i == hwlp_end_addr_i[g*HWLP_ADDR_W +: HWLP_ADDR_W])
                          && (cnt[g] != '0);
    end

    // descending scan so the lowest matching index is the final assignment
    always_comb begin
        match_any_o = 1'b0;
        sel_o       = '0;
        for (int i = N_HWLP - 1; i >= 0; i--) begin
            if (match[i]) begin
                match_any_o = 1'b1;
                sel_o       = N_HWLP_BITS'(i);
            end
        end
    end

    assign last_iter_o = (cnt[sel_o] == HWLP_ADDR_W'(1));
endmodule

// File: rtl/riscv_hwloop_controller.sv
// riscv_hwloop_controller: hardware-loop end detection, counter decrement and prefetcher jump request
// Optional feature macro: RISCV_HWLP_PERF_CNT_EN adds hwlp_jump_cnt_o (saturating count of acknowledged jumps).
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   current_pc_i      - PC of the instruction in ID
//   instr_valid_i     - ID instruction valid and retiring this cycle
//   hwlp_start_addr_i - packed loop start addresses
//   hwlp_end_addr_i   - packed loop end addresses
//   hwlp_counter_i    - packed remaining iteration counts
//   jump_ack_i        - prefetcher accepted the pending jump
//   hwlp_dec_cnt_o    - one-hot decrement request (combinational, IDLE only)
//   hwlp_jump_o       - registered jump request
//   hwlp_targ_addr_o  - jump target, zero outside JUMP_REQ
//   hwlp_busy_o       - high while in JUMP_REQ
//   hwlp_jump_cnt_o   - acknowledged jump count (RISCV_HWLP_PERF_CNT_EN only)
module riscv_hwloop_controller
    import riscv_hwlp_pkg::*;
#(
    parameter int N_HWLP      = N_HWLP_DEFAULT,
    parameter int N_HWLP_BITS = N_HWLP_BITS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [HWLP_ADDR_W-1:0]        current_pc_i,
    input  logic                          instr_valid_i,
    input  logic [N_HWLP*HWLP_ADDR_W-1:0] hwlp_start_addr_i,
    input  logic [N_HWLP*HWLP_ADDR_W-1:0] hwlp_end_addr_i,
    input  logic [N_HWLP*HWLP_ADDR_W-1:0] hwlp_counter_i,
    input  logic                          jump_ack_i,
    output logic [N_HWLP-1:0]             hwlp_dec_cnt_o,
    output logic                          hwlp_jump_o,
    output logic [HWLP_ADDR_W-1:0]        hwlp_targ_addr_o,
`ifdef RISCV_HWLP_PERF_CNT_EN
    output logic [31:0]                   hwlp_jump_cnt_o,
`endif
    output logic                          hwlp_busy_o
);
    hwlp_ctrl_state_e       state_q, state_d;
    logic [HWLP_ADDR_W-1:0] targ_q, targ_d;
    logic                   match_any;
    logic [N_HWLP_BITS-1:0] sel;
    logic                   last_iter;

    riscv_hwlp_match #(
        .N_HWLP      (N_HWLP),
        .N_HWLP_BITS (N_HWLP_BITS)
    ) u_match (
        .current_pc_i    (current_pc_i),
        .instr_valid_i   (instr_valid_i),
        .hwlp_end_addr_i (hwlp_end_addr_i),
        .hwlp_counter_i  (hwlp_counter_i),
        .match_any_o     (match_any),
        .sel_o           (sel),
        .last_iter_o     (last_iter)
    );

    // a pending jump is committed: matches and register-file updates are ignored until ack
    always_comb begin
        state_d        = state_q;
        targ_d         = targ_q;
        hwlp_dec_cnt_o = '0;
        if (state_q == IDLE) begin
            if (match_any) begin
                hwlp_dec_cnt_o[sel] = 1'b1;
                if (!last_iter) begin
                    state_d = JUMP_REQ;
                    targ_d  = hwlp_start_addr_i[sel*HWLP_ADDR_W +: HWLP_ADDR_W];
                end
            end
        end else if (jump_ack_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            targ_q  <= '0;
        end else begin
            state_q <= state_d;
            targ_q  <= targ_d;
        end
    end

    assign hwlp_jump_o      = (state_q == JUMP_REQ);
    assign hwlp_busy_o      = (state_q == JUMP_REQ);
    assign hwlp_targ_addr_o = (state_q == JUMP_REQ) ? targ_q : '0;

`ifdef RISCV_HWLP_PERF_CNT_EN
    logic [31:0] jump_cnt_q, jump_cnt_d;

    always_comb begin
        jump_cnt_d = (hwlp_jump_o && jump_ack_i && jump_cnt_q != '1) ? jump_cnt_q + 32'd1 : jump_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) jump_cnt_q <= '0;
        else        jump_cnt_q <= jump_cnt_d;
    end

    assign hwlp_jump_cnt_o = jump_cnt_q;
`endif
endmodule
